// File: rtl/strobe_log_pkg.sv
// +------------------------------------------------------------------+
// | strobe_log_pkg - shared types for the strobe log sampler  Rev 1.0 |
// +------------------------------------------------------------------+
`default_nettype none

package strobe_log_pkg;

  localparam int DEF_DATA_W = 32;
  localparam int DEF_TAG_W  = 8;
  localparam int DEF_DEPTH  = 4;
  localparam int DEF_CNT_W  = 8;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    DRAIN = 2'd1,
    DONE  = 2'd2
  } state_t;

  typedef struct packed {
    logic [DEF_TAG_W-1:0]  tag;
    logic [DEF_DATA_W-1:0] value;
  } record_t;

endpackage

`default_nettype wire

// File: rtl/strobe_rec_fifo.sv
// +------------------------------------------------------------------+
// | strobe_rec_fifo - sync record FIFO, push-when-full+pop legal Rev 1.0 |
// +------------------------------------------------------------------+
`default_nettype none

module strobe_rec_fifo #(
  parameter int WIDTH = 40,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push,
  input  logic [WIDTH-1:0]       push_data,
  input  logic                   pop,
  output logic [WIDTH-1:0]       head,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] level
);

  localparam int AW    = $clog2(DEPTH);
  localparam int LVL_W = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (level == '0);
  assign full    = (level == LVL_W'(DEPTH));
  assign do_pop  = pop && !empty;
  // A pop in the same cycle frees the slot the push needs.
  assign do_push = push && (!full || do_pop);
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   level <= level + LVL_W'(1);
        2'b01:   level <= level - LVL_W'(1);
        default: level <= level;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

`default_nettype wire

// File: rtl/strobe_log_sampler.sv
// +------------------------------------------------------------------+
// | strobe_log_sampler - postponed-value strobe capture and drain Rev 1.0 |
// +------------------------------------------------------------------+
`default_nettype none

module strobe_log_sampler
  import strobe_log_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int TAG_W  = DEF_TAG_W,
  parameter int DEPTH  = DEF_DEPTH,
  parameter int CNT_W  = DEF_CNT_W
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   strobe_req_i,
  input  logic [TAG_W-1:0]       strobe_tag_i,
  input  logic [DATA_W-1:0]      value_i,
  input  logic                   finish_req_i,
  output logic                   out_valid_o,
  input  logic                   out_ready_i,
  output logic [TAG_W-1:0]       out_tag_o,
  output logic [DATA_W-1:0]      out_value_o,
  output logic [$clog2(DEPTH):0] level_o,
  output logic [CNT_W-1:0]       drop_cnt_o,
  output logic                   overflow_o,
  output logic                   done_o
);

  localparam int LVL_W = $clog2(DEPTH) + 1;
  localparam int REC_W = TAG_W + DATA_W;

  state_t             state;
  state_t             state_nxt;
  logic               pend_valid;
  logic [TAG_W-1:0]   pend_tag;
  logic               accept_req;
  logic               drop_req;
  logic               drop_commit;
  logic               pop;
  logic               full;
  logic               empty;
  logic               fifo_empty_nxt;
  logic [REC_W-1:0]   head;
  logic [LVL_W-1:0]   level;
  logic [CNT_W:0]     drop_sum;

  assign accept_req  = strobe_req_i && (state == RUN);
  assign drop_req    = strobe_req_i && (state != RUN);
  assign pop         = !empty && out_ready_i;
  assign drop_commit = pend_valid && full && !pop;

  strobe_rec_fifo #(
    .WIDTH (REC_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (pend_valid),
    .push_data ({pend_tag, value_i}),
    .pop       (pop),
    .head      (head),
    .full      (full),
    .empty     (empty),
    .level     (level)
  );

  // The tag waits one cycle so value_i is captured after that cycle's writes land.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pend_valid <= 1'b0;
      pend_tag   <= '0;
    end else begin
      pend_valid <= accept_req;
      if (accept_req) pend_tag <= strobe_tag_i;
    end
  end

  // A late request and a failed commit can both drop in one cycle.
  assign drop_sum = {1'b0, drop_cnt_o} + (CNT_W+1)'(drop_req) + (CNT_W+1)'(drop_commit);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      drop_cnt_o <= '0;
      overflow_o <= 1'b0;
    end else begin
      drop_cnt_o <= drop_sum[CNT_W] ? '1 : drop_sum[CNT_W-1:0];
      if (drop_req || drop_commit) overflow_o <= 1'b1;
    end
  end

  assign fifo_empty_nxt = !pend_valid && (empty || (level == LVL_W'(1) && pop));

  always_ff @(posedge clk) begin
    if (!rst_n) state <= RUN;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      RUN:     if (finish_req_i) state_nxt = DRAIN;
      DRAIN:   if (fifo_empty_nxt) state_nxt = DONE;
      DONE:    state_nxt = DONE;
      default: state_nxt = RUN;
    endcase
  end

  assign out_valid_o = !empty;
  assign out_tag_o   = empty ? '0 : head[REC_W-1:DATA_W];
  assign out_value_o = empty ? '0 : head[DATA_W-1:0];
  assign level_o     = level;
  assign done_o      = (state == DONE);

endmodule

`default_nettype wire

// File: tb/tb_strobe_log_sampler.sv
// +------------------------------------------------------------------+
// | tb_strobe_log_sampler - scoreboard bench for strobe sampler Rev 1.0 |
// +------------------------------------------------------------------+
`default_nettype none

module tb_strobe_log_sampler;
  import strobe_log_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        strobe_req_i;
  logic [7:0]  strobe_tag_i;
  logic [31:0] value_i;
  logic        finish_req_i;
  logic        out_valid_o;
  logic        out_ready_i;
  logic [7:0]  out_tag_o;
  logic [31:0] out_value_o;
  logic [2:0]  level_o;
  logic [7:0]  drop_cnt_o;
  logic        overflow_o;
  logic        done_o;

  int      n_checks = 0;
  int      n_fail   = 0;
  record_t exp_q[$];
  record_t exp_rec;
  logic    was_pop;

  always #5 clk = ~clk;

  strobe_log_sampler dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .strobe_req_i (strobe_req_i),
    .strobe_tag_i (strobe_tag_i),
    .value_i      (value_i),
    .finish_req_i (finish_req_i),
    .out_valid_o  (out_valid_o),
    .out_ready_i  (out_ready_i),
    .out_tag_o    (out_tag_o),
    .out_value_o  (out_value_o),
    .level_o      (level_o),
    .drop_cnt_o   (drop_cnt_o),
    .overflow_o   (overflow_o),
    .done_o       (done_o)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n        = 1'b0;
    strobe_req_i = 1'b0;
    strobe_tag_i = '0;
    finish_req_i = 1'b0;
    out_ready_i  = 1'b0;
    value_i      = '0;
    tick();
    tick();
    exp_q.delete();
    rst_n = 1'b1;
  endtask

  task automatic wait_drain(input string name);
    int k = 0;
    while (exp_q.size() != 0 && k < 64) begin
      tick();
      k++;
    end
    check(name, 64'(exp_q.size()), 64'd0);
    tick();
  endtask

  // Scoreboard monitor: every accepted record must match the oldest expectation.
  always @(negedge clk) begin
    if (rst_n && out_valid_o && out_ready_i) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL record_unexpected: got tag 0x%0h value 0x%0h expected none", out_tag_o, out_value_o);
      end else begin
        exp_rec = exp_q.pop_front();
        if ({out_tag_o, out_value_o} !== exp_rec) begin
          n_fail++;
          $display("FAIL record: got tag 0x%0h value 0x%0h expected tag 0x%0h value 0x%0h",
                   out_tag_o, out_value_o, exp_rec.tag, exp_rec.value);
        end
      end
    end
  end

  initial begin
    do_reset();
    check("reset_valid", 64'(out_valid_o), 64'd0);
    check("reset_level", 64'(level_o), 64'd0);
    check("reset_drop", 64'(drop_cnt_o), 64'd0);
    check("reset_overflow", 64'(overflow_o), 64'd0);
    check("reset_done", 64'(done_o), 64'd0);
    check("reset_record", {out_tag_o, out_value_o}, 64'd0);

    // 1: value written at the request edge is the one captured
    out_ready_i  = 1'b1;
    strobe_req_i = 1'b1;
    strobe_tag_i = 8'd1;
    exp_q.push_back('{tag: 8'd1, value: 32'd1});
    tick();
    value_i      = 32'd1;
    strobe_req_i = 1'b0;
    check("t1_valid_cyc2", 64'(out_valid_o), 64'd0);
    tick();
    check("t1_valid_cyc3", 64'(out_valid_o), 64'd1);
    wait_drain("t1_drain");

    // 2: spaced requests, in-order records
    for (int k = 1; k <= 3; k++) begin
      strobe_req_i = 1'b1;
      strobe_tag_i = 8'(10 + k);
      exp_q.push_back('{tag: 8'(10 + k), value: 32'(k)});
      tick();
      value_i      = 32'(k);
      strobe_req_i = 1'b0;
      tick();
      tick();
    end
    wait_drain("t2_drain");
    check("t2_drop", 64'(drop_cnt_o), 64'd0);

    // 3: overflow with a stalled consumer
    out_ready_i = 1'b0;
    for (int i = 0; i < 6; i++) begin
      strobe_req_i = 1'b1;
      strobe_tag_i = 8'(20 + i);
      if (i < 4) exp_q.push_back('{tag: 8'(20 + i), value: 32'(100 + i)});
      tick();
      value_i = 32'(100 + i);
    end
    strobe_req_i = 1'b0;
    tick();
    check("t3_level", 64'(level_o), 64'd4);
    check("t3_drop", 64'(drop_cnt_o), 64'd2);
    check("t3_overflow", 64'(overflow_o), 64'd1);
    check("t3_head_tag", 64'(out_tag_o), 64'd20);
    out_ready_i = 1'b1;
    wait_drain("t3_drain");

    // 4: commit into a full FIFO while it pops
    out_ready_i = 1'b0;
    for (int i = 0; i < 5; i++) begin
      strobe_req_i = 1'b1;
      strobe_tag_i = 8'(30 + i);
      exp_q.push_back('{tag: 8'(30 + i), value: 32'(200 + i)});
      tick();
      value_i = 32'(200 + i);
    end
    strobe_req_i = 1'b0;
    out_ready_i  = 1'b1;
    check("t4_full_before", 64'(level_o), 64'd4);
    tick();
    check("t4_level_kept", 64'(level_o), 64'd4);
    check("t4_no_drop", 64'(drop_cnt_o), 64'd2);
    wait_drain("t4_drain");

    // 5: finish with 2 buffered + 1 pending, same-cycle and next-cycle requests
    do_reset();
    for (int i = 0; i < 5; i++) begin
      strobe_req_i = 1'b1;
      strobe_tag_i = 8'(40 + i);
      finish_req_i = (i == 3);
      if (i < 4) exp_q.push_back('{tag: 8'(40 + i), value: 32'(300 + i)});
      tick();
      value_i = 32'(300 + i);
      if (i == 3) check("t5_not_done_at_finish", 64'(done_o), 64'd0);
    end
    strobe_req_i = 1'b0;
    finish_req_i = 1'b0;
    check("t5_drop", 64'(drop_cnt_o), 64'd1);
    check("t5_level", 64'(level_o), 64'd4);
    out_ready_i = 1'b1;
    was_pop = 1'b0;
    for (int k = 0; k < 40 && !done_o; k++) begin
      was_pop = out_valid_o && out_ready_i;
      tick();
    end
    check("t5_done_seen", 64'(done_o), 64'd1);
    check("t5_done_after_last_pop", 64'(was_pop), 64'd1);
    check("t5_all_out", 64'(exp_q.size()), 64'd0);
    strobe_req_i = 1'b1;
    finish_req_i = 1'b1;
    strobe_tag_i = 8'd99;
    tick();
    strobe_req_i = 1'b0;
    finish_req_i = 1'b0;
    tick();
    check("t5_done_drop", 64'(drop_cnt_o), 64'd2);
    check("t5_done_held", 64'(done_o), 64'd1);
    check("t5_done_no_valid", 64'(out_valid_o), 64'd0);

    // 6: reset during drain discards buffered records
    do_reset();
    for (int i = 0; i < 3; i++) begin
      strobe_req_i = 1'b1;
      strobe_tag_i = 8'(50 + i);
      tick();
      value_i = 32'(500 + i);
    end
    strobe_req_i = 1'b0;
    tick();
    check("t6_level_pre", 64'(level_o), 64'd3);
    finish_req_i = 1'b1;
    tick();
    finish_req_i = 1'b0;
    check("t6_drain_not_done", 64'(done_o), 64'd0);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check("t6_valid", 64'(out_valid_o), 64'd0);
    check("t6_level", 64'(level_o), 64'd0);
    check("t6_done", 64'(done_o), 64'd0);
    out_ready_i  = 1'b1;
    strobe_req_i = 1'b1;
    strobe_tag_i = 8'd60;
    exp_q.push_back('{tag: 8'd60, value: 32'd400});
    tick();
    value_i      = 32'd400;
    strobe_req_i = 1'b0;
    tick();
    tick();
    wait_drain("t6_run_after_reset");
    check("t6_drop", 64'(drop_cnt_o), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
